// File: rtl/var_delay_line_if.sv
// Handshake/data bundle for var_delay_line: stream in, tapped stream out, delay control.
interface var_delay_line_if #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned MAX_DELAY  = 16
) ();
  localparam int unsigned DEL_W = $clog2(MAX_DELAY + 1);

  logic                  en;
  logic                  flush;
  logic                  delay_load;
  logic [DEL_W-1:0]      delay_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [DEL_W-1:0]      delay_cur;
  logic                  busy;

  modport master (
    output en, flush, delay_load, delay_in, data_in, valid_in,
    input  data_out, valid_out, delay_cur, busy
  );

  modport slave (
    input  en, flush, delay_load, delay_in, data_in, valid_in,
    output data_out, valid_out, delay_cur, busy
  );
endinterface

// File: rtl/var_delay_line.sv
// Variable-length shift delay line with a selectable tap, clamped runtime delay
// and a settle window that suppresses valid_out after every delay change.
module var_delay_line #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned MAX_DELAY  = 16
) (
  input  logic            clk,
  input  logic            rst,
  var_delay_line_if.slave bus
);
  localparam int unsigned DEL_W = $clog2(MAX_DELAY + 1);
  localparam int unsigned IDX_W = $clog2(MAX_DELAY);

  generate
    if (MAX_DELAY < 2 || MAX_DELAY > 256) begin : g_max_delay_check
      $error("var_delay_line: MAX_DELAY must be in 2..256");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] data_q [MAX_DELAY];
  logic [DATA_WIDTH-1:0] data_d [MAX_DELAY];
  logic [MAX_DELAY-1:0]  valid_q, valid_d;
  logic [DEL_W-1:0]      delay_q, delay_d;
  logic [DEL_W-1:0]      cnt_q, cnt_d;
  logic [DEL_W-1:0]      delay_clamped_c;
  logic [IDX_W-1:0]      tap_c;

  // Requested delay forced into the legal 1..MAX_DELAY window.
  always_comb begin
    delay_clamped_c = bus.delay_in;
    if (bus.delay_in == '0) begin
      delay_clamped_c = DEL_W'(1);
    end else if (bus.delay_in > DEL_W'(MAX_DELAY)) begin
      delay_clamped_c = DEL_W'(MAX_DELAY);
    end
  end

  // Next-state: shift on en, flush clears tags, delay_load overrides the counter.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    delay_d = delay_q;
    cnt_d   = cnt_q;

    if (bus.en) begin
      data_d[0] = bus.data_in;
      for (int i = 1; i < int'(MAX_DELAY); i++) begin
        data_d[i] = data_q[i-1];
      end
      valid_d = {valid_q[MAX_DELAY-2:0], bus.valid_in};
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DEL_W'(1);
      end
    end

    if (bus.flush) begin
      valid_d = '0;
    end

    if (bus.delay_load) begin
      delay_d = delay_clamped_c;
      cnt_d   = delay_clamped_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
      delay_q <= DEL_W'(MAX_DELAY);
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
    end
  end

  // delay_q is never 0, so D-1 always lands on a real stage.
  assign tap_c         = IDX_W'(delay_q - DEL_W'(1));
  assign bus.data_out  = data_q[tap_c];
  assign bus.valid_out = valid_q[tap_c] & (cnt_q == '0);
  assign bus.busy      = (cnt_q != '0);
  assign bus.delay_cur = delay_q;
endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line (DATA_WIDTH=8, MAX_DELAY=16) with hand-derived expectations.
module tb_var_delay_line;
  localparam int unsigned DW = 8;
  localparam int unsigned MD = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  var_delay_line_if #(.DATA_WIDTH(DW), .MAX_DELAY(MD)) bus ();

  var_delay_line #(.DATA_WIDTH(DW), .MAX_DELAY(MD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic v, input logic b);
    check({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
    check({tag, ".busy"},  32'(bus.busy),      32'(b));
    if (v) check({tag, ".data"}, 32'(bus.data_out), d);
  endtask

  // Stall pattern and the tap value expected after each edge (D=3).
  logic        stall_en  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0]  stall_in  [6] = '{8'd38, 8'hEE, 8'hEE, 8'd39, 8'd40, 8'd41};
  logic [7:0]  stall_exp [6] = '{8'd36, 8'd36, 8'd36, 8'd37, 8'd38, 8'd39};

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.flush = 1'b0; bus.delay_load = 1'b0;
    bus.delay_in = '0; bus.data_in = '0; bus.valid_in = 1'b0;
    step();
    check("rst.data_out",  32'(bus.data_out),  32'h0);
    check("rst.valid_out", 32'(bus.valid_out), 32'h0);
    check("rst.busy",      32'(bus.busy),      32'h0);
    check("rst.delay_cur", 32'(bus.delay_cur), 32'd16);
    rst = 1'b0;

    // Ramp at default delay 16; word c is presented before edge c.
    bus.en = 1'b1; bus.valid_in = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      bus.data_in = 8'(c);
      step();
      check_out($sformatf("ramp%0d", c), 32'(c - 15), c >= 16, 1'b0);
    end

    // Load delay 4 mid-stream: busy for 4 edges, then tap = stage 3.
    for (int c = 21; c <= 30; c++) begin
      bus.data_in    = 8'(c);
      bus.delay_load = (c == 21);
      bus.delay_in   = 5'd4;
      step();
      bus.delay_load = 1'b0;
      if (c == 21) check("d4.delay_cur", 32'(bus.delay_cur), 32'd4);
      check(.tag($sformatf("d4.%0d.data", c)), .obs(32'(bus.data_out)), .exp(32'(c - 3)));
      check_out($sformatf("d4.%0d", c), 32'(c - 3), c >= 25, c <= 24);
    end

    // Clamp high, then clamp low (restarts the settle counter at 1).
    bus.data_in = 8'd31; bus.delay_load = 1'b1; bus.delay_in = 5'd31;
    step();
    check("clamp31.delay_cur", 32'(bus.delay_cur), 32'd16);
    check("clamp31.busy",      32'(bus.busy),      32'd1);
    bus.data_in = 8'd32; bus.delay_in = 5'd0;
    step();
    bus.delay_load = 1'b0;
    check("clamp0.delay_cur", 32'(bus.delay_cur), 32'd1);
    check("clamp0.busy",      32'(bus.busy),      32'd1);
    check("clamp0.valid",     32'(bus.valid_out), 32'd0);
    check("clamp0.data",      32'(bus.data_out),  32'd32);
    bus.data_in = 8'd33;
    step();
    check_out("d1", 32'd33, 1'b1, 1'b0);

    // D=3, settle over edges 35..37, then stall pattern.
    for (int c = 34; c <= 37; c++) begin
      bus.data_in    = 8'(c);
      bus.delay_load = (c == 34);
      bus.delay_in   = 5'd3;
      step();
      bus.delay_load = 1'b0;
      check_out($sformatf("d3.%0d", c), 32'(c - 2), c == 37, c < 37);
    end
    for (int i = 0; i < 6; i++) begin
      bus.en      = stall_en[i];
      bus.data_in = stall_in[i];
      step();
      check_out($sformatf("stall%0d", i), 32'(stall_exp[i]), 1'b1, 1'b0);
    end
    bus.en = 1'b1;

    // Flush and load 5 together; 0x50 is discarded, 0x51 is the first survivor.
    bus.data_in = 8'h50; bus.flush = 1'b1; bus.delay_load = 1'b1; bus.delay_in = 5'd5;
    step();
    bus.flush = 1'b0; bus.delay_load = 1'b0;
    check("flush.delay_cur", 32'(bus.delay_cur), 32'd5);
    check_out("flush.j0", 32'h0, 1'b0, 1'b1);
    for (int j = 1; j <= 7; j++) begin
      bus.data_in = 8'(8'h50 + j);
      step();
      check_out($sformatf("flush.j%0d", j), 32'(8'h50 + j - 4), j >= 5, j < 5);
    end

    // Reset while settling after a load of 7.
    bus.data_in = 8'h60; bus.delay_load = 1'b1; bus.delay_in = 5'd7;
    step();
    bus.delay_load = 1'b0;
    check("pre_rst.busy", 32'(bus.busy), 32'd1);
    rst = 1'b1; bus.delay_load = 1'b1; bus.delay_in = 5'd2; bus.flush = 1'b1;
    step();
    rst = 1'b0; bus.delay_load = 1'b0; bus.flush = 1'b0;
    check("midrst.busy",      32'(bus.busy),      32'h0);
    check("midrst.valid_out", 32'(bus.valid_out), 32'h0);
    check("midrst.data_out",  32'(bus.data_out),  32'h0);
    check("midrst.delay_cur", 32'(bus.delay_cur), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/var_delay_line.md
VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, bit width of each data word.
REQ-002 SHALL have parameter MAX_DELAY, default 16, number of storage stages and largest selectable delay (legal range 2..256).
REQ-003 SHALL derive DEL_W = clog2(MAX_DELAY+1) as the delay field width.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports clk and rst.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  advance strobe; stages shift only on edges with en=1.
REQ-008 flush  input  1  clear all valid tags.
REQ-009 delay_load  input  1  latch delay_in as the new active delay.
REQ-010 delay_in  input  DEL_W  requested delay, in enabled cycles.
REQ-011 data_in  input  DATA_WIDTH  input word.
REQ-012 valid_in  input  1  qualifies data_in.
REQ-013 data_out  output  DATA_WIDTH  word at selected tap.
REQ-014 valid_out  output  1  qualifies data_out.
REQ-015 delay_cur  output  DEL_W  active (clamped) delay.
REQ-016 busy  output  1  high while settling after a delay change.

Function
REQ-017 Each of the MAX_DELAY stages SHALL hold a data word plus a valid tag.
- Tag and data of stage 0 load from valid_in/data_in.
- Stage i loads from stage i-1.
- All of this happens on an edge with en=1. With en=0, every stage holds.
REQ-018 With active delay D, data_out and valid_out SHALL be driven combinationally from stage D-1, with no additional register.
- A word captured on enabled edge n SHALL appear on data_out after enabled edge n+D-1.
- Example: with en held high, it appears D cycles after presentation.
REQ-019 On delay_load=1, the active delay SHALL update at that edge, independent of en.
- delay_in=0 SHALL clamp to 1.
- delay_in>MAX_DELAY SHALL clamp to MAX_DELAY.
- delay_cur shows the clamped value from the next cycle.
REQ-020 A delay_load SHALL preset the settle counter to the new clamped D, even if D equals the old value.
- Counter decrements by 1 on each enabled edge while non-zero.
- busy = (counter != 0).
REQ-021 While busy=1, valid_out SHALL be forced 0. data_out continues to follow the selected tap.
- This ensures no word is duplicated or replayed across a delay change.
REQ-022 flush=1 SHALL clear every stage's valid tag at that edge, regardless of en.
- Data contents are unspecified after flush.
- valid_in presented on that edge is also discarded.
REQ-023 Simultaneous flush and delay_load SHALL both take effect on the same edge.
REQ-024 A delay_load while already busy SHALL restart the settle counter from the new D.
REQ-025 delay_load with en=1 on the same edge:
- The shift occurs.
- The counter loads D; it does not load D-1.
REQ-026 MAX_DELAY=1 configurations SHALL NOT be supported; elaboration SHALL fail on MAX_DELAY<2 via a generate-time check.

Reset
REQ-027 On rst=1, at that edge:
- All stage data SHALL clear to 0.
- All valid tags SHALL clear to 0.
- The settle counter SHALL clear to 0.
- The active delay SHALL be set to MAX_DELAY.
REQ-028 Outputs after reset: data_out=0, valid_out=0, busy=0, delay_cur=MAX_DELAY.
REQ-029 rst SHALL take priority over flush, delay_load and en on the same edge.
- Reset asserted mid-settle or mid-stream SHALL discard all in-flight words.

Verification
REQ-030 Default delay: DATA_WIDTH=8, MAX_DELAY=16, en=1, ramp 0x01,0x02,... with valid_in=1 after reset -> 0x01 on data_out with valid_out=1 exactly 16 cycles after presentation; valid_out=0 before that.
REQ-031 Delay change: load delay_in=4 mid-stream -> busy=1 for 4 enabled cycles, valid_out=0 throughout; then each word emerges 4 cycles after presentation with no gap or repeat.
REQ-032 Clamping: delay_in=0 -> delay_cur=1, one-cycle latency; delay_in=31 -> delay_cur=16.
REQ-033 Stall: D=3, en toggled 1,0,0,1,1,... -> output order preserved, and each word is held while en=0.
REQ-034 Flush vs. load: flush and delay_load(5) together on one edge mid-stream -> valid_out=0 for at least 5 enabled cycles, then only words presented after that edge appear.
REQ-035 Reset mid-settle: rst during busy=1 -> the next cycle shows busy=0, valid_out=0, data_out=0, delay_cur=16.
